// File: rtl/sram_l2_burst.sv
// Parametrised behavioural L2 backing store: single-beat reads/writes and fixed-length bursts,
// with a fixed-latency read response pipeline carrying tag and last-beat flag.
module sram_l2_burst #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 12,
    parameter int TAG_W     = 5,
    parameter int BURST_LEN = 4,
    parameter int RD_LAT    = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_req_val,
    output logic              mem_req_rdy,
    input  logic [1:0]        mem_req_rw,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_data,
    input  logic [TAG_W-1:0]  mem_req_tag,
    output logic              mem_resp_val,
    output logic              mem_resp_last,
    output logic              mem_resp_nack,
    output logic [DATA_W-1:0] mem_resp_data,
    output logic [TAG_W-1:0]  mem_resp_tag,
    output logic [1:0]        o_dbg_state
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_BURST = 2'd1,
        S_WR_BURST = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_active;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [TAG_W-1:0]  r_tag;

    logic              w_accept;
    logic              w_cnt_end;
    logic [ADDR_W-1:0] w_burst_addr;
    logic              w_rd_issue;
    logic              w_rd_last;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [TAG_W-1:0]  w_rd_tag;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_s0_val;
    logic              r_s0_last;
    logic [TAG_W-1:0]  r_s0_tag;
    logic [DATA_W-1:0] r_s0_data;
    logic              r_p_val  [RD_LAT-1];
    logic              r_p_last [RD_LAT-1];
    logic [TAG_W-1:0]  r_p_tag  [RD_LAT-1];
    logic [DATA_W-1:0] r_p_data [RD_LAT-1];

    // Handshake: a beat transfers on a posedge where mem_req_val and mem_req_rdy are both 1.
    assign mem_req_rdy  = r_active & (r_state != S_RD_BURST);
    assign w_accept     = mem_req_val & mem_req_rdy;
    assign w_cnt_end    = (r_cnt == CNT_W'(BURST_LEN - 1));
    assign w_burst_addr = r_base + ADDR_W'(r_cnt);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !mem_req_rw[1])
                    w_state_nxt = mem_req_rw[0] ? S_WR_BURST : S_RD_BURST;
            end
            S_RD_BURST: if (w_cnt_end) w_state_nxt = S_IDLE;
            S_WR_BURST: if (w_accept && w_cnt_end) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_issue = 1'b0;
        w_rd_last  = 1'b0;
        w_rd_addr  = w_burst_addr;
        w_rd_tag   = r_tag;
        w_wr_en    = 1'b0;
        w_wr_addr  = w_burst_addr;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (mem_req_rw[0]) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = mem_req_addr;
                    end else begin
                        w_rd_issue = 1'b1;
                        w_rd_addr  = mem_req_addr;
                        w_rd_tag   = mem_req_tag;
                        w_rd_last  = mem_req_rw[1];
                    end
                end
            end
            S_RD_BURST: begin
                w_rd_issue = 1'b1;
                w_rd_last  = w_cnt_end;
            end
            S_WR_BURST: w_wr_en = w_accept;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_base <= '0;
            r_tag  <= '0;
        end else begin
            if (r_state == S_IDLE && w_accept && !mem_req_rw[1]) begin
                r_cnt  <= CNT_W'(1);
                r_base <= mem_req_addr;
                r_tag  <= mem_req_tag;
            end else if (r_state == S_RD_BURST || (r_state == S_WR_BURST && w_accept)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Write gated by reset_n so a beat presented alongside reset never lands in the array.
    always_ff @(posedge clk) begin
        if (reset_n && w_wr_en)
            r_mem[w_wr_addr] <= mem_req_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s0_val  <= 1'b0;
            r_s0_last <= 1'b0;
            r_s0_tag  <= '0;
            r_s0_data <= '0;
        end else begin
            r_s0_val  <= w_rd_issue;
            r_s0_last <= w_rd_issue & w_rd_last;
            r_s0_tag  <= w_rd_issue ? w_rd_tag : '0;
            r_s0_data <= w_rd_issue ? r_mem[w_rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT - 1; i++) begin
                r_p_val[i]  <= 1'b0;
                r_p_last[i] <= 1'b0;
                r_p_tag[i]  <= '0;
                r_p_data[i] <= '0;
            end
        end else begin
            r_p_val[0]  <= r_s0_val;
            r_p_last[0] <= r_s0_last;
            r_p_tag[0]  <= r_s0_tag;
            r_p_data[0] <= r_s0_data;
            for (int i = 1; i < RD_LAT - 1; i++) begin
                r_p_val[i]  <= r_p_val[i-1];
                r_p_last[i] <= r_p_last[i-1];
                r_p_tag[i]  <= r_p_tag[i-1];
                r_p_data[i] <= r_p_data[i-1];
            end
        end
    end

    assign mem_resp_val  = r_p_val[RD_LAT-2];
    assign mem_resp_last = r_p_last[RD_LAT-2];
    assign mem_resp_tag  = r_p_tag[RD_LAT-2];
    assign mem_resp_data = r_p_data[RD_LAT-2];
    assign mem_resp_nack = 1'b0;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sram_l2_burst.sv
// Directed plus randomized bench for sram_l2_burst; expected responses come from a
// cycle-indexed schedule built from an address-keyed memory model.
module tb_sram_l2_burst;

    localparam int DATA_W    = 128;
    localparam int ADDR_W    = 12;
    localparam int TAG_W     = 5;
    localparam int BURST_LEN = 4;
    localparam int RD_LAT    = 3;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mem_req_val = 1'b0;
    logic              mem_req_rdy;
    logic [1:0]        mem_req_rw = 2'b00;
    logic [ADDR_W-1:0] mem_req_addr = '0;
    logic [DATA_W-1:0] mem_req_data = '0;
    logic [TAG_W-1:0]  mem_req_tag = '0;
    logic              mem_resp_val;
    logic              mem_resp_last;
    logic              mem_resp_nack;
    logic [DATA_W-1:0] mem_resp_data;
    logic [TAG_W-1:0]  mem_resp_tag;
    logic [1:0]        dbg_state;

    sram_l2_burst #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W),
        .BURST_LEN(BURST_LEN), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_resp_val(mem_resp_val), .mem_resp_last(mem_resp_last),
        .mem_resp_nack(mem_resp_nack), .mem_resp_data(mem_resp_data),
        .mem_resp_tag(mem_resp_tag), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic              last;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t             exp_map [int];
    logic [DATA_W-1:0] mem_model [int];
    logic [DATA_W-1:0] wdata [BURST_LEN];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // One clock: sample #1 after the edge and compare the response port to the schedule.
    task automatic tick();
        resp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_map.exists(cyc)) begin
            e = exp_map[cyc];
            exp_map.delete(cyc);
            chk("resp_val", DATA_W'(mem_resp_val), DATA_W'(1'b1));
            chk("resp_tag", DATA_W'(mem_resp_tag), DATA_W'(e.tag));
            chk("resp_last", DATA_W'(mem_resp_last), DATA_W'(e.last));
            chk("resp_data", mem_resp_data, e.data);
        end else begin
            chk("resp_idle", DATA_W'(mem_resp_val), '0);
        end
        chk("resp_nack", DATA_W'(mem_resp_nack), '0);
    endtask

    task automatic do_read(input logic single, input int addr, input logic [TAG_W-1:0] tag);
        resp_t e;
        int n;
        int a;
        chk("rdy_before_read", DATA_W'(mem_req_rdy), DATA_W'(1'b1));
        mem_req_val  = 1'b1;
        mem_req_rw   = {single, 1'b0};
        mem_req_addr = ADDR_W'(addr);
        mem_req_tag  = tag;
        mem_req_data = rnd_data();
        n = single ? 1 : BURST_LEN;
        for (int b = 0; b < n; b++) begin
            a = (addr + b) % DEPTH;
            e.tag  = tag;
            e.last = single || (b == n - 1);
            e.data = mem_model[a];
            exp_map[cyc + RD_LAT + b] = e;
        end
        tick();
        mem_req_val = 1'b0;
        if (!single) begin
            repeat (BURST_LEN - 1) begin
                chk("rdy_rd_busy", DATA_W'(mem_req_rdy), '0);
                tick();
            end
        end
    endtask

    task automatic single_write(input int addr, input logic [DATA_W-1:0] d);
        chk("rdy_before_swr", DATA_W'(mem_req_rdy), DATA_W'(1'b1));
        mem_req_val  = 1'b1;
        mem_req_rw   = 2'b11;
        mem_req_addr = ADDR_W'(addr);
        mem_req_tag  = TAG_W'($urandom());
        mem_req_data = d;
        tick();
        mem_model[addr % DEPTH] = d;
        mem_req_val = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int max_bubble);
        chk("rdy_before_bwr", DATA_W'(mem_req_rdy), DATA_W'(1'b1));
        mem_req_val  = 1'b1;
        mem_req_rw   = 2'b01;
        mem_req_addr = ADDR_W'(addr);
        mem_req_tag  = TAG_W'($urandom());
        mem_req_data = wdata[0];
        tick();
        mem_model[addr % DEPTH] = wdata[0];
        for (int b = 1; b < BURST_LEN; b++) begin
            repeat ($urandom_range(max_bubble, 0)) begin
                mem_req_val  = 1'b0;
                mem_req_data = rnd_data();
                chk("rdy_wr_bubble", DATA_W'(mem_req_rdy), DATA_W'(1'b1));
                tick();
            end
            mem_req_val  = 1'b1;
            mem_req_rw   = 2'($urandom_range(3, 0));
            mem_req_addr = ADDR_W'($urandom());
            mem_req_tag  = TAG_W'($urandom());
            mem_req_data = wdata[b];
            chk("rdy_wr_beat", DATA_W'(mem_req_rdy), DATA_W'(1'b1));
            tick();
            mem_model[(addr + b) % DEPTH] = wdata[b];
        end
        mem_req_val = 1'b0;
    endtask

    task automatic fill_rand();
        for (int b = 0; b < BURST_LEN; b++) wdata[b] = rnd_data();
    endtask

    initial begin
        logic [DATA_W-1:0] old_val;
        int op;
        int a;

        // Reset held for three cycles.
        repeat (3) begin
            tick();
            chk("rdy_in_reset", DATA_W'(mem_req_rdy), '0);
            chk("resp_data_reset", mem_resp_data, '0);
            chk("resp_tag_reset", DATA_W'(mem_resp_tag), '0);
            chk("resp_last_reset", DATA_W'(mem_resp_last), '0);
        end
        chk("dbg_state_reset", DATA_W'(dbg_state), '0);
        reset_n = 1'b1;
        chk("rdy_release_cycle", DATA_W'(mem_req_rdy), '0);
        tick();
        chk("rdy_after_reset", DATA_W'(mem_req_rdy), DATA_W'(1'b1));

        // Burst write A0..A3 then burst read tag 5.
        for (int b = 0; b < BURST_LEN; b++) wdata[b] = DATA_W'(8'hA0 + b);
        write_burst('h010, 0);
        do_read(1'b0, 'h010, 5'd5);

        // Wrap at the top of the array, checked beat by beat with single reads.
        fill_rand();
        write_burst('hFFE, 0);
        do_read(1'b1, 'hFFE, 5'd10);
        do_read(1'b1, 'hFFF, 5'd11);
        do_read(1'b1, 'h000, 5'd12);
        do_read(1'b1, 'h001, 5'd13);

        // Write burst with bubbles between beats.
        fill_rand();
        write_burst('h300, 3);
        do_read(1'b0, 'h300, 5'd20);

        // Single read immediately followed by a burst read.
        do_read(1'b1, 'h010, 5'd1);
        do_read(1'b0, 'h300, 5'd2);
        repeat (RD_LAT + BURST_LEN) tick();

        // Reset in the second cycle of a read burst: nothing may come back.
        chk("rdy_before_abort", DATA_W'(mem_req_rdy), DATA_W'(1'b1));
        mem_req_val  = 1'b1;
        mem_req_rw   = 2'b00;
        mem_req_addr = ADDR_W'('h010);
        mem_req_tag  = 5'd7;
        tick();
        mem_req_val = 1'b0;
        reset_n     = 1'b0;
        repeat (2) begin
            tick();
            chk("rdy_abort_reset", DATA_W'(mem_req_rdy), '0);
        end
        reset_n = 1'b1;
        tick();
        chk("rdy_after_abort", DATA_W'(mem_req_rdy), DATA_W'(1'b1));
        repeat (RD_LAT + BURST_LEN) tick();
        do_read(1'b0, 'h010, 5'd8);
        repeat (RD_LAT + BURST_LEN) tick();

        // Reset on the third beat of a write burst: that beat must not land.
        old_val = rnd_data();
        single_write('h202, old_val);
        fill_rand();
        mem_req_val  = 1'b1;
        mem_req_rw   = 2'b01;
        mem_req_addr = ADDR_W'('h200);
        mem_req_data = wdata[0];
        tick();
        mem_model['h200] = wdata[0];
        mem_req_data = wdata[1];
        tick();
        mem_model['h201] = wdata[1];
        mem_req_data = wdata[2];
        reset_n      = 1'b0;
        tick();
        mem_req_val = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("rdy_after_wr_abort", DATA_W'(mem_req_rdy), DATA_W'(1'b1));
        do_read(1'b1, 'h202, 5'd3);
        do_read(1'b1, 'h201, 5'd4);
        do_read(1'b1, 'h200, 5'd5);

        // Randomized traffic in a prefilled window.
        for (int i = 0; i < 16; i++) begin
            fill_rand();
            write_burst('h100 + i * BURST_LEN, 1);
        end
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(3, 0);
            case (op)
                0: do_read(1'b0, $urandom_range('h100 + 64 - BURST_LEN, 'h100), TAG_W'($urandom()));
                1: do_read(1'b1, $urandom_range('h13F, 'h100), TAG_W'($urandom()));
                2: begin
                    fill_rand();
                    write_burst($urandom_range('h100 + 64 - BURST_LEN, 'h100), 2);
                end
                default: begin
                    a = $urandom_range('h13F, 'h100);
                    single_write(a, rnd_data());
                end
            endcase
            repeat ($urandom_range(2, 0)) tick();
        end

        repeat (RD_LAT + BURST_LEN + 2) tick();
        chk("all_responses_seen", DATA_W'(exp_map.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
